// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter:
// FSM state encoding, ALU op codes and the registered-operation control struct.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    // Op codes are carried through to the shared ALU untouched; named here
    // only so surrounding code and benches can refer to them symbolically.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

    // Width-independent part of an accepted operation; the N-bit operands
    // live beside it in the top level because N is a module parameter.
    typedef struct packed {
        logic [2:0] ctrl;
        logic [4:0] shamt;
        logic       owner;
    } op_ctrl_t;

    // Requester index encoded by a one-hot two-way grant.
    function automatic logic grant_owner(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selector. The grant is combinational so the
// requester sees ready in the same cycle it raises valid; the priority
// pointer (last_grant_r) only advances when the caller signals an accept.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // 1 means requester 1 was granted last, so requester 0 wins the next tie.
    logic last_grant_r;
    logic [1:0] gnt_s;

    // Select a single winner: lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = last_grant_r ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
        endcase
    end

    assign gnt = gnt_s;

    // Advance the priority pointer only on an actual accept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant_r <= 1'b1;
        end else if (update) begin
            last_grant_r <= gnt_s[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters. Each operation walks
// IDLE -> ISSUE -> RESP: operands are latched on accept, presented to the
// ALU for exactly one cycle, and the result is held for the owner until it
// is taken. Optional grant statistics are built only when the macro
// ALU_ARB_STATS_EN is defined; otherwise gnt_cnt0/gnt_cnt1 are tied to zero.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req0_ctrl,
    input  logic [2:0]   req1_ctrl,
    input  logic [4:0]   req0_shamt,
    input  logic [4:0]   req1_shamt,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    input  logic         rsp0_ready,
    input  logic         rsp1_ready,
    output logic [N-1:0] rsp0_result,
    output logic [N-1:0] rsp1_result,
    output logic         rsp0_zero,
    output logic         rsp1_zero,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_control,
    output logic [4:0]   alu_shamt,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    output logic [15:0]  gnt_cnt0,
    output logic [15:0]  gnt_cnt1
);

    arb_state_e   state_r;
    logic [N-1:0] op_a_r;
    logic [N-1:0] op_b_r;
    op_ctrl_t     op_r;
    logic [N-1:0] res_r;
    logic         zero_r;
    logic [1:0]   rsp_valid_r;

    logic [1:0]   req_s;
    logic [1:0]   gnt_s;
    logic         accept_s;
    logic         rsp_done_s;

    assign req_s = {req1_valid, req0_valid};

    // reset_n gates accept so ready stays low for the whole reset window.
    assign accept_s = reset_n && (state_r == IDLE) && (req_s != 2'b00);

    assign rsp_done_s = (state_r == RESP) &&
                        (op_r.owner ? (rsp_valid_r[1] && rsp1_ready)
                                    : (rsp_valid_r[0] && rsp0_ready));

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_s),
        .update  (accept_s),
        .gnt     (gnt_s)
    );

    assign req0_ready  = accept_s && gnt_s[0];
    assign req1_ready  = accept_s && gnt_s[1];

    assign rsp0_valid  = rsp_valid_r[0];
    assign rsp1_valid  = rsp_valid_r[1];
    assign rsp0_result = res_r;
    assign rsp1_result = res_r;
    assign rsp0_zero   = zero_r;
    assign rsp1_zero   = zero_r;

    // Operation FSM: latch on accept, capture the ALU in ISSUE, hold the response until taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            op_a_r      <= '0;
            op_b_r      <= '0;
            op_r        <= '0;
            res_r       <= '0;
            zero_r      <= 1'b0;
            rsp_valid_r <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_a_r      <= gnt_s[1] ? req1_a     : req0_a;
                        op_b_r      <= gnt_s[1] ? req1_b     : req0_b;
                        op_r.ctrl   <= gnt_s[1] ? req1_ctrl  : req0_ctrl;
                        op_r.shamt  <= gnt_s[1] ? req1_shamt : req0_shamt;
                        op_r.owner  <= grant_owner(gnt_s);
                        state_r     <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_r       <= alu_result;
                    zero_r      <= alu_zero;
                    rsp_valid_r <= op_r.owner ? 2'b10 : 2'b01;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_done_s) begin
                        rsp_valid_r <= 2'b00;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Present the latched operation to the ALU only during ISSUE; a quiet ADD of zeros otherwise.
    always_comb begin
        if (state_r == ISSUE) begin
            alu_a       = op_a_r;
            alu_b       = op_b_r;
            alu_control = op_r.ctrl;
            alu_shamt   = op_r.shamt;
        end else begin
            alu_a       = '0;
            alu_b       = '0;
            alu_control = ALU_ADD;
            alu_shamt   = 5'd0;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt_cnt0_r;
    logic [15:0] gnt_cnt1_r;

    // Count accepts per requester, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt_cnt0_r <= 16'h0000;
            gnt_cnt1_r <= 16'h0000;
        end else begin
            if (req0_ready && (gnt_cnt0_r != 16'hFFFF)) begin
                gnt_cnt0_r <= gnt_cnt0_r + 16'h0001;
            end
            if (req1_ready && (gnt_cnt1_r != 16'hFFFF)) begin
                gnt_cnt1_r <= gnt_cnt1_r + 16'h0001;
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt0_r;
    assign gnt_cnt1 = gnt_cnt1_r;
`else
    assign gnt_cnt0 = 16'h0000;
    assign gnt_cnt1 = 16'h0000;
`endif

endmodule
